// File: rtl/iir_pkg.sv
// Shared types and constants for the IIR coefficient loader.
// Optional feature macro: COEFF_CHECKSUM_EN (adds the CHECK state).
package iir_pkg;

  localparam int unsigned DEF_TAP_WIDTH    = 16;
  localparam int unsigned DEF_FF_TAP_COUNT = 4;
  localparam int unsigned DEF_FB_TAP_COUNT = 3;
  localparam int unsigned DEF_UNITY_SHIFT  = DEF_TAP_WIDTH - 3;

`ifdef COEFF_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DRAIN,
    ST_PEND
  } load_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_PEND
  } load_state_e;
`endif

  // Unity-gain coefficient for a given output scaling shift.
  function automatic logic [31:0] unity_coeff(input int unsigned shift);
    return 32'd1 << shift;
  endfunction

endpackage

// File: rtl/iir_coeff_bank.sv
// Shadow/active coefficient register pair. Shadow is written word by word;
// commit copies it to the active bank in one edge. Reset gives pass-through.
module iir_coeff_bank
  import iir_pkg::*;
#(
  parameter int unsigned TAP_WIDTH   = DEF_TAP_WIDTH,
  parameter int unsigned TAP_COUNT   = DEF_FF_TAP_COUNT + DEF_FB_TAP_COUNT,
  parameter int unsigned UNITY_SHIFT = TAP_WIDTH - 3,
  parameter int unsigned IDX_WIDTH   = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [IDX_WIDTH-1:0]           wr_idx,
  input  logic [TAP_WIDTH-1:0]           wr_data,
  input  logic                           clear,
  input  logic                           commit,
  output logic [TAP_COUNT*TAP_WIDTH-1:0] active
);

  localparam int unsigned SEL_WIDTH = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;
  localparam logic [TAP_WIDTH-1:0] UNITY = TAP_WIDTH'(unity_coeff(UNITY_SHIFT));

  logic [TAP_WIDTH-1:0] shadow [TAP_COUNT];
  logic [TAP_WIDTH-1:0] act    [TAP_COUNT];
  logic [SEL_WIDTH-1:0] sel;

  assign sel = SEL_WIDTH'(wr_idx);

  // Shadow bank: cleared on reset or frame error, otherwise written by index.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int unsigned i = 0; i < TAP_COUNT; i++) shadow[i] <= '0;
    end else if (wr_en && (32'(wr_idx) < TAP_COUNT)) begin
      shadow[sel] <= wr_data;
    end
  end

  // Active bank: pass-through on reset, whole-bank copy on commit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act[0] <= UNITY;
      for (int unsigned i = 1; i < TAP_COUNT; i++) act[i] <= '0;
    end else if (commit) begin
      act <= shadow;
    end
  end

  // Pack active taps, tap 0 in the LSBs.
  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < TAP_COUNT; i++) begin
      active[i*TAP_WIDTH +: TAP_WIDTH] = act[i];
    end
  end

endmodule

// File: rtl/iir_coeff_loader.sv
// Framed coefficient loader for the variable IIR filter. Stages B then A taps
// in a shadow bank and swaps them to the active bank on a sample strobe.
// Optional feature macro: COEFF_CHECKSUM_EN (trailing zero-sum checksum word).
module iir_coeff_loader
  import iir_pkg::*;
#(
  parameter int unsigned TAP_WIDTH    = DEF_TAP_WIDTH,
  parameter int unsigned FF_TAP_COUNT = DEF_FF_TAP_COUNT,
  parameter int unsigned FB_TAP_COUNT = DEF_FB_TAP_COUNT,
  parameter int unsigned UNITY_SHIFT  = TAP_WIDTH - 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [TAP_WIDTH-1:0]              s_data,
  input  logic                              s_last,
  input  logic                              sample_strobe,
  output logic [FF_TAP_COUNT*TAP_WIDTH-1:0] b_coeffs,
  output logic [FB_TAP_COUNT*TAP_WIDTH-1:0] a_coeffs,
  output logic                              coeff_swap,
  output logic                              load_err,
  output logic                              busy
);

  localparam int unsigned COEF_COUNT = FF_TAP_COUNT + FB_TAP_COUNT;
`ifdef COEFF_CHECKSUM_EN
  localparam int unsigned WORD_COUNT = COEF_COUNT + 1;
`else
  localparam int unsigned WORD_COUNT = COEF_COUNT;
`endif
  localparam int unsigned CNT_WIDTH = $clog2(WORD_COUNT + 1);

  load_state_e                     state, state_next;
  logic [CNT_WIDTH-1:0]            cnt, cnt_next;
  logic                            xfer, is_final;
  logic                            wr_en, clear, commit, err_next;
  logic [COEF_COUNT*TAP_WIDTH-1:0] active;

  assign s_ready  = reset_n && (state == ST_IDLE || state == ST_LOAD || state == ST_DRAIN);
  assign xfer     = s_valid && s_ready;
  assign is_final = (32'(cnt) == WORD_COUNT - 1);
  assign busy     = reset_n && (state != ST_IDLE);

`ifdef COEFF_CHECKSUM_EN
  logic [TAP_WIDTH-1:0] acc;

  // Running modulo-2^W sum of the frame; restarts on the first word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (xfer) begin
      acc <= ((cnt == '0) ? '0 : acc) + s_data;
    end
  end
`endif

  // State, word counter and registered one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      load_err   <= 1'b0;
      coeff_swap <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      load_err   <= err_next;
      coeff_swap <= commit;
    end
  end

  // Next-state, shadow write/clear and commit decode.
  // IDLE and LOAD share one path: in IDLE the counter is always zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wr_en      = 1'b0;
    clear      = 1'b0;
    commit     = 1'b0;
    err_next   = 1'b0;
    unique case (state)
      ST_IDLE, ST_LOAD: begin
        if (xfer) begin
          wr_en = (32'(cnt) < COEF_COUNT);
          if (is_final) begin
            cnt_next = '0;
            if (s_last) begin
`ifdef COEFF_CHECKSUM_EN
              state_next = ST_CHECK;
`else
              state_next = ST_PEND;
`endif
            end else begin
              err_next   = 1'b1;
              clear      = 1'b1;
              state_next = ST_DRAIN;
            end
          end else if (s_last) begin
            err_next   = 1'b1;
            clear      = 1'b1;
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else begin
            cnt_next   = cnt + CNT_WIDTH'(1);
            state_next = ST_LOAD;
          end
        end
      end
`ifdef COEFF_CHECKSUM_EN
      ST_CHECK: begin
        if (acc == '0) begin
          state_next = ST_PEND;
        end else begin
          err_next   = 1'b1;
          clear      = 1'b1;
          state_next = ST_IDLE;
        end
      end
`endif
      ST_DRAIN: begin
        if (xfer && s_last) state_next = ST_IDLE;
      end
      ST_PEND: begin
        if (sample_strobe) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  iir_coeff_bank #(
    .TAP_WIDTH  (TAP_WIDTH),
    .TAP_COUNT  (COEF_COUNT),
    .UNITY_SHIFT(UNITY_SHIFT),
    .IDX_WIDTH  (CNT_WIDTH)
  ) u_bank (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .wr_idx (cnt),
    .wr_data(s_data),
    .clear  (clear),
    .commit (commit),
    .active (active)
  );

  assign b_coeffs = active[FF_TAP_COUNT*TAP_WIDTH-1:0];
  assign a_coeffs = active[COEF_COUNT*TAP_WIDTH-1:FF_TAP_COUNT*TAP_WIDTH];

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Self-checking bench for iir_coeff_loader: directed frames plus random
// good/short/long frames against a frame-level reference model.
// Honours COEFF_CHECKSUM_EN when defined for the whole build.
module tb_iir_coeff_loader;

  localparam int unsigned TW    = 16;
  localparam int unsigned NFF   = 4;
  localparam int unsigned NFB   = 3;
  localparam int unsigned NCOEF = NFF + NFB;
`ifdef COEFF_CHECKSUM_EN
  localparam int unsigned NW = NCOEF + 1;
`else
  localparam int unsigned NW = NCOEF;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          sample_strobe = 1'b0;
  logic [TW-1:0] s_data = '0;
  logic          s_ready, coeff_swap, load_err, busy;
  logic [63:0]   b_coeffs;
  logic [47:0]   a_coeffs;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int swap_seen = 0;

  logic [TW-1:0] coef    [NCOEF];
  logic [TW-1:0] frame_w [NW+4];
  logic [63:0]   exp_b;
  logic [47:0]   exp_a;

  iir_coeff_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .sample_strobe(sample_strobe),
    .b_coeffs     (b_coeffs),
    .a_coeffs     (a_coeffs),
    .coeff_swap   (coeff_swap),
    .load_err     (load_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (load_err === 1'b1) err_seen++;
    if (coeff_swap === 1'b1) swap_seen++;
  endtask

  function automatic logic [63:0] model_b();
    logic [63:0] v = '0;
    for (int i = 0; i < NFF; i++) v = v | (64'(coef[i]) << (TW * i));
    return v;
  endfunction

  function automatic logic [47:0] model_a();
    logic [47:0] v = '0;
    for (int i = 0; i < NFB; i++) v = v | (48'(coef[NFF+i]) << (TW * i));
    return v;
  endfunction

  task automatic randomize_coef();
    for (int i = 0; i < NCOEF; i++) coef[i] = TW'($urandom);
  endtask

  // Frame words: coefficients, optional checksum, then random filler.
  task automatic build_words(input bit bad_ck);
    logic [TW-1:0] sum = '0;
    for (int i = 0; i < NCOEF; i++) begin
      frame_w[i] = coef[i];
      sum = sum + coef[i];
    end
`ifdef COEFF_CHECKSUM_EN
    frame_w[NCOEF] = TW'(0) - sum + (bad_ck ? TW'(1) : TW'(0));
`else
    if (bad_ck) sum = '0;
`endif
    for (int i = NW; i < NW + 4; i++) frame_w[i] = TW'($urandom);
  endtask

  task automatic send_word(input logic [TW-1:0] d, input logic last);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (s_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    chk("ready_wait", 64'(s_ready), 64'(1));
    step();
  endtask

  task automatic strobe_commit_ok(input string tag);
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    exp_b = model_b();
    exp_a = model_a();
    chk({tag, "_b"}, b_coeffs, exp_b);
    chk({tag, "_a"}, 64'(a_coeffs), 64'(exp_a));
    chk({tag, "_swap"}, 64'(coeff_swap), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  // Send a frame of len words (s_last on the final one) and check outcome.
  task automatic run_frame(input string tag, input int len, input bit bad_ck,
                           input int delay, input bit strobe_on_last);
    bit good = (len == NW) && !bad_ck;
    build_words(bad_ck);
    err_seen  = 0;
    swap_seen = 0;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1 && strobe_on_last) sample_strobe = 1'b1;
      send_word(frame_w[i], (i == len - 1));
      sample_strobe = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    step();
    chk({tag, "_errs"}, 64'(err_seen), good ? 64'(0) : 64'(1));
    if (good) begin
      chk({tag, "_pend_busy"}, 64'(busy), 64'(1));
      chk({tag, "_pend_ready"}, 64'(s_ready), 64'(0));
      for (int i = 0; i < delay; i++) step();
      chk({tag, "_hold_b"}, b_coeffs, exp_b);
      chk({tag, "_hold_a"}, 64'(a_coeffs), 64'(exp_a));
      strobe_commit_ok(tag);
      step();
      chk({tag, "_swap_once"}, 64'(swap_seen), 64'(1));
    end else begin
      chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
      chk({tag, "_idle_ready"}, 64'(s_ready), 64'(1));
      sample_strobe = 1'b1;
      step();
      sample_strobe = 1'b0;
      step();
      chk({tag, "_noswap"}, 64'(swap_seen), 64'(0));
      chk({tag, "_keep_b"}, b_coeffs, exp_b);
      chk({tag, "_keep_a"}, 64'(a_coeffs), 64'(exp_a));
    end
  endtask

  initial begin
    int y;
    logic [63:0] f1_b;
    logic [47:0] f1_a;
    exp_b = 64'h0000_0000_0000_2000;
    exp_a = '0;

    // Reset behaviour.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(s_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_swap", 64'(coeff_swap), 64'(0));
    chk("rst_err", 64'(load_err), 64'(0));
    reset_n = 1'b1;
    step();
    chk("rel_ready", 64'(s_ready), 64'(1));
    chk("rel_b", b_coeffs, exp_b);
    chk("rel_a", 64'(a_coeffs), 64'(exp_a));
    y = (100 * int'($signed(b_coeffs[15:0]))) >>> 13;
    chk("filter_passthru", 64'(y), 64'(100));

    // Directed frame; strobe alongside the last word must not commit.
    coef = '{16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'hF000, 16'h0100, 16'h0000};
    run_frame("dir", NW, 1'b0, 3, 1'b1);
    chk("dir_swap_off", 64'(coeff_swap), 64'(0));

    // Early s_last on word 3, then a good frame.
    randomize_coef();
    run_frame("short3", 3, 1'b0, 0, 1'b0);
    run_frame("after_short", NW, 1'b0, 1, 1'b0);

    // Missing s_last on the final word, two extra words drained.
    randomize_coef();
    run_frame("drain", NW + 2, 1'b0, 0, 1'b0);

`ifdef COEFF_CHECKSUM_EN
    randomize_coef();
    run_frame("ck_good", NW, 1'b0, 2, 1'b0);
    run_frame("ck_bad", NW, 1'b1, 0, 1'b0);
`endif

    // s_valid held through PEND: nothing consumed until after the swap.
    randomize_coef();
    build_words(1'b0);
    for (int i = 0; i < NW; i++) send_word(frame_w[i], (i == NW - 1));
    f1_b = model_b();
    f1_a = model_a();
    randomize_coef();
    build_words(1'b0);
    s_valid = 1'b1;
    s_data  = frame_w[0];
    s_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pend_ready", 64'(s_ready), 64'(0));
    end
    sample_strobe = 1'b1;
    step();
    sample_strobe = 1'b0;
    chk("pend_b", b_coeffs, f1_b);
    chk("pend_a", 64'(a_coeffs), 64'(f1_a));
    chk("pend_swap", 64'(coeff_swap), 64'(1));
    step();
    for (int i = 1; i < NW; i++) send_word(frame_w[i], (i == NW - 1));
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    step();
    strobe_commit_ok("post_pend");

    // Random mix of good, short and over-long frames.
    for (int n = 0; n < 10; n++) begin
      int kind = int'($urandom_range(0, 3));
      randomize_coef();
      if (kind < 2)
        run_frame("rnd_good", NW, 1'b0, int'($urandom_range(0, 4)), 1'b0);
      else if (kind == 2)
        run_frame("rnd_short", int'($urandom_range(1, NW - 1)), 1'b0, 0, 1'b0);
      else
        run_frame("rnd_long", NW + int'($urandom_range(1, 3)), 1'b0, 0, 1'b0);
    end

    // Reset while in PEND restores pass-through taps.
    randomize_coef();
    build_words(1'b0);
    for (int i = 0; i < NW; i++) send_word(frame_w[i], (i == NW - 1));
    s_valid = 1'b0;
    s_last  = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    exp_b = 64'h0000_0000_0000_2000;
    exp_a = '0;
    chk("mid_rst_ready", 64'(s_ready), 64'(0));
    chk("mid_rst_b", b_coeffs, exp_b);
    chk("mid_rst_a", 64'(a_coeffs), 64'(exp_a));
    reset_n = 1'b1;
    step();
    chk("mid_rel_busy", 64'(busy), 64'(0));
    chk("mid_rel_ready", 64'(s_ready), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iir_coeff_loader.md
# iir_coeff_loader

Coefficient writer for the variable IIR filter. Accepts a framed stream of feed-forward (B) and feedback (A) taps over a valid/ready interface and stages them in a shadow bank. On a sample boundary it atomically swaps them into the active bank that drives the filter's coefficient inputs, so the filter never sees a half-updated tap set.

## Interface
Parameters:
- TAP_WIDTH, 16, coefficient word width (signed)
- FF_TAP_COUNT, 4, number of B taps
- FB_TAP_COUNT, 3, number of A taps (A[0] of the recursion is implicit unity and is not loaded)
- UNITY_SHIFT, TAP_WIDTH-3, filter output scaling; unity gain = 1 << UNITY_SHIFT

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- s_valid  in  1  coefficient word valid
- s_ready  out  1  loader can accept a word
- s_data  in  TAP_WIDTH  coefficient word, signed
- s_last  in  1  final word of frame
- sample_strobe  in  1  filter sample boundary; commit allowed on this cycle
- b_coeffs  out  FF_TAP_COUNT*TAP_WIDTH  active B taps, B[0] in LSBs
- a_coeffs  out  FB_TAP_COUNT*TAP_WIDTH  active A taps, A[0] in LSBs
- coeff_swap  out  1  one-cycle pulse after active bank update
- load_err  out  1  one-cycle pulse on frame error
- busy  out  1  frame in progress or commit pending

## Operation
- Frame word order: B[0]..B[FF_TAP_COUNT-1], then A[0]..A[FB_TAP_COUNT-1], then optional checksum (see Configuration). N = FF_TAP_COUNT+FB_TAP_COUNT (+1 with checksum).
- A word transfers on a cycle where s_valid and s_ready are both high. It is written to the shadow bank at index = word counter. The counter increments on each transfer.
- FSM states:
  - IDLE: s_ready=1. First transfer goes to LOAD. A single-word frame (s_last on word 1) with N>1 is an error.
  - LOAD: s_ready=1. The transfer of word N with s_last=1 goes to PEND (or CHECK). s_last=1 before word N is an error: pulse load_err and return to IDLE. Word N with s_last=0 is an error: pulse load_err and go to DRAIN.
  - CHECK (macro only): one cycle with s_ready=0. On pass go to PEND. On fail pulse load_err and go to IDLE.
  - DRAIN: s_ready=1. Words are discarded. The transfer with s_last=1 returns to IDLE.
  - PEND: s_ready=0. When sample_strobe=1, copy shadow to active, pulse coeff_swap, and return to IDLE.
- Any error discards the shadow contents. The active bank is untouched.
- busy=1 in LOAD, CHECK, DRAIN, PEND.
- No arithmetic on coefficients. Words are stored verbatim as two's complement.

## Timing
- Reset values: s_ready=0 during reset and 1 the first cycle after release (IDLE). b_coeffs has B[0]=1<<UNITY_SHIFT (8192 at defaults) and all other B taps 0, so the filter is pass-through. a_coeffs is all 0. coeff_swap=0, load_err=0, busy=0. Shadow bank and counter are cleared.
- Reset asserted mid-frame or in PEND abandons the frame. Active taps return to reset values.
- Commit latency: last word accepted at edge E, giving PEND from E (or CHECK at E, PEND at E+1). sample_strobe high while in PEND is sampled at edge M. b_coeffs/a_coeffs change at M, and coeff_swap is high for the cycle following M.
- sample_strobe in the same cycle as the final word transfer does not commit. The commit occurs at the next strobe seen in PEND.
- sample_strobe in IDLE, LOAD or DRAIN is ignored.
- load_err is high for exactly one cycle, the cycle after the offending transfer edge (or after the CHECK cycle).
- Throughput: one word per cycle in LOAD and DRAIN. The minimum frame-to-frame gap is the PEND wait plus one IDLE cycle.

## Configuration
- COEFF_CHECKSUM_EN defined: the frame carries an extra final word.
  - The checksum passes when the modulo-2^TAP_WIDTH sum of all N words, including the checksum, equals 0.
  - The checksum word is not stored. CHECK state is present.
- COEFF_CHECKSUM_EN undefined: N = FF_TAP_COUNT+FB_TAP_COUNT. There is no CHECK state and no accumulator. The last coefficient word goes directly to PEND.

## Structure
- Package iir_pkg holds:
  - the loader state enum
  - default TAP_WIDTH, FF_TAP_COUNT and FB_TAP_COUNT constants
  - the UNITY_SHIFT constant
  - a function returning the unity coefficient value
- Sub-module iir_coeff_bank holds the shadow/active register pair with write-enable/index and commit inputs, and provides the reset-to-pass-through values. The FSM, counter and checksum logic stay in iir_coeff_loader.

## Test plan
- Reset release: b_coeffs = 0x0000_0000_0000_2000 and a_coeffs = 0. Filter input 100 produces output 100.
- Load frame B={0x1000,0x0800,0x0400,0x0200}, A={0xF000,0x0100,0x0000} with s_last on word 7; strobe 5 cycles later.
  - No change before the strobe edge.
  - Taps match the frame at that edge; coeff_swap is a single pulse; busy drops the next cycle.
- s_last on word 3: load_err pulses and the active taps are unchanged. The next well-formed frame commits normally.
- Word 7 without s_last, then 2 extra words with s_last on the second: load_err pulses once, the extra words are drained, and there is no swap.
- s_valid held high in PEND for 10 cycles: s_ready=0 and no words are consumed. Words are consumed after the swap.
- COEFF_CHECKSUM_EN: frame with checksum equal to the negated sum commits. The same frame with the checksum off by 1 gives a load_err pulse and no swap.
